// File: rtl/led_drv_pkg.sv
// led_drv_pkg: state encoding and counter-width helper shared by led_serial_driver and its phase tick.
package led_drv_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_e;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/led_drv_tick.sv
// led_drv_tick: CLK_DIV-cycle phase counter, emits phase_end_o on the last cycle of each phase.
module led_drv_tick
  import led_drv_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic phase_end_o
);
  localparam int PW = cnt_w(CLK_DIV);
  logic [PW-1:0] phase_q, phase_d;
  assign phase_end_o = en_i && (phase_q == PW'(CLK_DIV - 1));
  always_comb phase_d = (clr_i || phase_end_o) ? '0 : en_i ? phase_q + PW'(1) : phase_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) phase_q <= '0;
    else phase_q <= phase_d;
endmodule

// File: rtl/led_serial_driver.sv
// led_serial_driver: shifts a WIDTH-bit frame MSB-first to a 74HC595-style chain, then pulses the latch.
// Define LED_DRV_PENDING_EN to add a one-deep pending buffer for loads that arrive while busy.
module led_serial_driver
  import led_drv_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] frame_i,
  input  logic             load_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             sclk_o,
  output logic             sdata_o,
  output logic             latch_o
);
  localparam int BW = cnt_w(WIDTH);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic             done_d, phase_end, accept;
  assign accept = load_i && (state_q == IDLE);
  led_drv_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (accept),
    .en_i       (state_q != IDLE),
    .phase_end_o(phase_end)
  );
`ifdef LED_DRV_PENDING_EN
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  always_comb begin
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    if (state_q == LATCH && phase_end) pend_v_d = 1'b0;
    else if (load_i && state_q != IDLE) begin
      pend_d   = frame_i;
      pend_v_d = 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pend_q   <= '0;
      pend_v_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
    end
`endif
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (load_i) begin
        state_d = SHIFT_LO;
        sr_d    = frame_i;
        bit_d   = '0;
      end
      SHIFT_LO: if (phase_end) state_d = SHIFT_HI;
      SHIFT_HI: if (phase_end) begin
        if (bit_q == BW'(WIDTH - 1)) state_d = LATCH;
        else begin
          state_d = SHIFT_LO;
          sr_d    = sr_q << 1;
          bit_d   = bit_q + BW'(1);
        end
      end
      LATCH: if (phase_end) begin
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef LED_DRV_PENDING_EN
        // a load on this very edge is the latest request, so it beats the buffered one
        if (pend_v_q || load_i) begin
          state_d = SHIFT_LO;
          sr_d    = load_i ? frame_i : pend_q;
          bit_d   = '0;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sclk_o  <= 1'b0;
      sdata_o <= 1'b0;
      latch_o <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bit_q   <= bit_d;
      busy_o  <= state_d != IDLE;
      done_o  <= done_d;
      sclk_o  <= state_d == SHIFT_HI;
      latch_o <= state_d == LATCH;
      if (state_d == SHIFT_LO || state_d == SHIFT_HI) sdata_o <= sr_d[WIDTH-1];
    end
endmodule

// File: tb/tb_led_serial_driver.sv
// tb_led_serial_driver: timing-based reference model for the 16/4 driver plus a vector table for a 4/1 instance.
module tb_led_serial_driver;
  localparam int W = 16, D = 4, TOT = (2 * W + 1) * D;
  logic clk = 1'b0, rst = 1'b1;
  logic load_i = 1'b0;
  logic [W-1:0] frame_i = '0;
  logic busy_o, done_o, sclk_o, sdata_o, latch_o;
  logic load2 = 1'b0;
  logic [3:0] frame2 = '0;
  logic busy2, done2, sclk2, sdata2, latch2;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;

  led_serial_driver #(.WIDTH(W), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .frame_i(frame_i), .load_i(load_i), .busy_o(busy_o),
    .done_o(done_o), .sclk_o(sclk_o), .sdata_o(sdata_o), .latch_o(latch_o));
  led_serial_driver #(.WIDTH(4), .CLK_DIV(1)) dut2 (
    .clk(clk), .rst(rst), .frame_i(frame2), .load_i(load2), .busy_o(busy2),
    .done_o(done2), .sclk_o(sclk2), .sdata_o(sdata2), .latch_o(latch2));

  // model: time elapsed since acceptance fully determines the waveform
  logic m_act, m_pv, m_sd;
  int m_t;
  logic [W-1:0] m_f, m_pf;
  logic e_busy, e_done, e_sclk, e_sdata, e_latch;
  logic [63:0] cap;
  int rises, dones, latches, busys;
  logic prev_sclk;

  task automatic model_reset();
    m_act = 0; m_pv = 0; m_sd = 0; m_t = 0; m_f = '0; m_pf = '0;
    e_busy = 0; e_done = 0; e_sclk = 0; e_sdata = 0; e_latch = 0;
  endtask

  task automatic model_step(input logic ld, input logic [W-1:0] fr);
    int s;
    e_done = 0;
    if (m_act) begin
      m_t++;
      if (m_t == TOT) begin
        e_done = 1;
        m_act = 0;
`ifdef LED_DRV_PENDING_EN
        if (m_pv || ld) begin
          m_act = 1; m_t = 0; m_f = ld ? fr : m_pf; m_pv = 0;
        end
`endif
      end
`ifdef LED_DRV_PENDING_EN
      else if (ld) begin
        m_pf = fr; m_pv = 1;
      end
`endif
    end else if (ld) begin
      m_act = 1; m_t = 0; m_f = fr;
    end
    s = m_t / D;
    e_busy  = m_act;
    e_sclk  = m_act && s < 2 * W && s % 2 == 1;
    e_latch = m_act && s == 2 * W;
    if (m_act) m_sd = (s < 2 * W) ? m_f[W-1-s/2] : m_f[0];
    e_sdata = m_sd;
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, got, got, want, want);
    end
  endtask

  task automatic cyc(input logic ld, input logic [W-1:0] fr, input string nm);
    load_i = ld; frame_i = fr;
    @(posedge clk);
    model_step(ld, fr);
    #1;
    n_vec++;
    if ({busy_o, done_o, sclk_o, sdata_o, latch_o} !== {e_busy, e_done, e_sclk, e_sdata, e_latch}) begin
      n_bad++;
      $display("FAIL %s at %0t: busy/done/sclk/sdata/latch got %b%b%b%b%b want %b%b%b%b%b", nm, $time,
               busy_o, done_o, sclk_o, sdata_o, latch_o, e_busy, e_done, e_sclk, e_sdata, e_latch);
    end
    if (sclk_o && !prev_sclk) begin
      cap = {cap[62:0], sdata_o};
      rises++;
    end
    prev_sclk = sclk_o;
    dones += int'(done_o); latches += int'(latch_o); busys += int'(busy_o);
    load_i = 0;
  endtask

  task automatic clr_stats();
    cap = '0; rises = 0; dones = 0; latches = 0; busys = 0;
  endtask

  typedef struct {
    logic       ld;
    logic [3:0] fr;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int done_at, busy_at;
    model_reset();
    prev_sclk = 0;
    clr_stats();
    tbl[0]  = '{1'b1, 4'b1001, 5'b10010};
    tbl[1]  = '{1'b0, 4'b0000, 5'b10110};
    tbl[2]  = '{1'b0, 4'b0000, 5'b10000};
    tbl[3]  = '{1'b0, 4'b0000, 5'b10100};
    tbl[4]  = '{1'b0, 4'b0000, 5'b10000};
    tbl[5]  = '{1'b0, 4'b0000, 5'b10100};
    tbl[6]  = '{1'b0, 4'b0000, 5'b10010};
    tbl[7]  = '{1'b0, 4'b0000, 5'b10110};
    tbl[8]  = '{1'b0, 4'b0000, 5'b10011};
    tbl[9]  = '{1'b0, 4'b0000, 5'b01010};
    tbl[10] = '{1'b1, 4'b0110, 5'b10000};
    tbl[11] = '{1'b0, 4'b0000, 5'b10100};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) cyc(0, W'($urandom), "idle");
    for (int i = 0; i < 12; i++) begin
      load2 = tbl[i].ld; frame2 = tbl[i].fr;
      @(posedge clk);
      #1;
      n_vec++;
      if ({busy2, done2, sclk2, sdata2, latch2} !== tbl[i].exp) begin
        n_bad++;
        $display("FAIL small_tbl[%0d]: busy/done/sclk/sdata/latch got %b%b%b%b%b want %b", i,
                 busy2, done2, sclk2, sdata2, latch2, tbl[i].exp);
      end
      load2 = 0;
    end
    // A5C3 with frame_i scrambled every cycle after acceptance
    clr_stats();
    done_at = -1;
    for (int i = 0; i < 140; i++) begin
      cyc(i == 0, (i == 0) ? 16'hA5C3 : W'($urandom), "a5c3");
      if (done_o) done_at = i;
    end
    check_int("a5c3_bits", int'(cap[15:0]), 16'hA5C3);
    check_int("a5c3_rises", rises, 16);
    check_int("a5c3_latch_cycles", latches, 4);
    check_int("a5c3_done_at", done_at, TOT);
    clr_stats();
    busy_at = -1;
    for (int i = 0; i < 300; i++) begin
`ifdef LED_DRV_PENDING_EN
      cyc(i == 0 || i == 20 || i == 40, (i == 0) ? 16'h1234 : (i == 20) ? 16'h0F0F : (i == 40) ? 16'h8001 : 16'h0, "pend");
`else
      cyc(i == 0 || i == 50, (i == 0) ? 16'hFFFF : (i == 50) ? 16'h0001 : 16'h0, "drop");
`endif
      if (i == TOT) busy_at = int'(busy_o);
    end
`ifdef LED_DRV_PENDING_EN
    check_int("pend_bits", int'(cap[31:0]), 32'h12348001);
    check_int("pend_rises", rises, 32);
    check_int("pend_dones", dones, 2);
    check_int("pend_busy_cycles", busys, 2 * TOT);
    check_int("pend_busy_at_132", busy_at, 1);
`else
    check_int("drop_bits", int'(cap[15:0]), 16'hFFFF);
    check_int("drop_rises", rises, 16);
    check_int("drop_dones", dones, 1);
    check_int("drop_busy_at_132", busy_at, 0);
`endif
    for (int i = 0; i < 3000; i++) cyc($urandom_range(0, 39) == 0, W'($urandom), "random");
    for (int i = 0; i < 300; i++) cyc(0, W'($urandom), "drain");
    // reset during bit 5 must clear everything at once and suppress the latch
    for (int i = 0; i < 42; i++) cyc(i == 0, (i == 0) ? 16'hFFFF : W'($urandom), "pre_rst");
    #2 rst = 1;
    #1;
    check_int("async_rst_outputs", int'({busy_o, done_o, sclk_o, sdata_o, latch_o}), 0);
    model_reset();
    prev_sclk = 0;
    @(posedge clk);
    #1 rst = 0;
    clr_stats();
    for (int i = 0; i < 150; i++) cyc(0, W'($urandom), "post_rst");
    check_int("post_rst_latches", latches, 0);
    check_int("post_rst_dones", dones, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
